// File: rtl/tdes_sequencer.sv
// tdes_sequencer
//   Runs the three passes of a 3DES operation on an external single-DES core.
//   Each pass drives text/key/direction from registers, raises core_select,
//   waits for core_done, latches the result back into the text register and
//   waits for core_done to fall before the next pass. A per-pass watchdog
//   aborts the whole request when the core never answers.
//
//   Build option: define TDES_DECRYPT_EN to honour in_dir_i (3DES decrypt).
//   Without it the encrypt pass order is always used and in_dir_i is ignored.
//
// Ports
//   clk_sys_i, rst_n_i        clock, async active-low reset
//   in_valid_i / in_ready_o   request handshake (ready only in IDLE)
//   in_block_i, in_k1_i..k3_i request block and keys (parity bits unused)
//   in_dir_i                  0 = encrypt, 1 = decrypt
//   out_valid_o / out_ready_i result handshake
//   out_block_o, out_err_o    result block, watchdog-abort flag
//   core_select_o             start/hold to DES core
//   core_text_o, core_key_o   operands to DES core
//   core_decrypt_o            DES core direction for current pass
//   core_result_i, core_done_i DES core result and level completion flag
//
// States
//   S_IDLE      | waiting for a request, in_ready high
//   S_ISSUE     | pass operands stable, waiting for core_done low
//   S_WAIT_DONE | core_select high, watchdog counting
//   S_RELEASE   | core_select low, waiting for core_done to fall
//   S_OUT       | result presented until out_ready

module tdes_sequencer #(
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] in_block_i,
    input  logic [63:0] in_k1_i,
    input  logic [63:0] in_k2_i,
    input  logic [63:0] in_k3_i,
    input  logic        in_dir_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_block_o,
    output logic        out_err_o,
    output logic        core_select_o,
    output logic [63:0] core_text_o,
    output logic [63:0] core_key_o,
    output logic        core_decrypt_o,
    input  logic [63:0] core_result_i,
    input  logic        core_done_i
);

    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RELEASE,
        S_OUT
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    pass_q, pass_d;
    logic [63:0]   text_q, text_d;
    logic [63:0]   k1_q, k2_q, k3_q;
    logic          err_q, err_d;
    logic          sel_q, sel_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          accept;
    logic          dir_eff;

`ifdef TDES_DECRYPT_EN
    logic dir_q;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dir_q <= 1'b0;
        end else if (accept) begin
            dir_q <= in_dir_i;
        end
    end

    assign dir_eff = dir_q;
`else
    logic unused_dir;
    assign unused_dir = in_dir_i;
    assign dir_eff    = 1'b0;
`endif

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pass_q  <= 2'd0;
            text_q  <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            err_q   <= 1'b0;
            sel_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            text_q  <= text_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            wdog_q  <= wdog_d;
            if (accept) begin
                k1_q <= in_k1_i;
                k2_q <= in_k2_i;
                k3_q <= in_k3_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        text_d  = text_q;
        err_d   = err_q;
        sel_d   = sel_q;
        wdog_d  = wdog_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    accept  = 1'b1;
                    text_d  = in_block_i;
                    pass_d  = 2'd0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d = '0;
                // A core still reporting done from a previous pass must settle first.
                if (!core_done_i) begin
                    sel_d   = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // core_done is tested first so a same-cycle completion beats expiry.
                if (core_done_i) begin
                    text_d  = core_result_i;
                    sel_d   = 1'b0;
                    state_d = S_RELEASE;
                end else if (wdog_q == WD_LAST) begin
                    text_d  = '0;
                    err_d   = 1'b1;
                    sel_d   = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_RELEASE: begin
                if (!core_done_i) begin
                    if (err_q || pass_q == 2'd2) begin
                        state_d = S_OUT;
                    end else begin
                        pass_d  = pass_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pass schedule: encrypt E(K1) D(K2) E(K3); decrypt D(K3) E(K2) D(K1).
    always_comb begin
        core_key_o = k3_q;
        case (pass_q)
            2'd0:    core_key_o = dir_eff ? k3_q : k1_q;
            2'd1:    core_key_o = k2_q;
            default: core_key_o = dir_eff ? k1_q : k3_q;
        endcase
    end

    assign core_decrypt_o = (pass_q == 2'd1) ^ dir_eff;
    assign core_text_o    = text_q;
    assign core_select_o  = sel_q;
    assign in_ready_o     = (state_q == S_IDLE);
    assign out_valid_o    = (state_q == S_OUT);
    assign out_block_o    = (state_q == S_OUT) ? text_q : '0;
    assign out_err_o      = (state_q == S_OUT) & err_q;

endmodule
